pll_rst_seq: RTL and testbench

//  Sequencer for the PLL and the system reset tree. Runs on a free-running board clock.
//  - Drives PLL RESETB and waits for a stable lock; times out and retries.
//  - Releases N staged, active-high logic resets, lowest index first.
//  - Re-sequences on lock loss or on a software reset request.

---
 rtl/pll_rst_seq.sv | 199 +++++++++++++++++++
 tb/tb_pll_rst_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL RESETB driver and staged logic-reset sequencer.
//
// Sequence: hold the PLL in reset, wait for lock (with timeout and retry),
// require a run of consecutive lock cycles, then release N active-high
// domain resets lowest index first, STAGE_GAP cycles apart. Losing lock,
// or a software request, restarts the sequence.
//
// Optional feature macro: PLL_RST_SEQ_LOSS_CNT_EN
//   defined   -> loss_cnt counts lock losses seen in RUN (saturating at 255)
//   undefined -> loss_cnt is tied to zero and has no flops
//
// The FSM state register 'state' is a plain typed signal so checkers can
// bind to it hierarchically.
//
// Handshakes: none. sw_rst_req is a single-cycle request pulse sampled on
// every clk edge; pll_lock is asynchronous and only used after synchronising.
module pll_rst_seq #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int LOCK_TIMEOUT       = 65535,
  parameter int STAGE_GAP          = 8,
  parameter int N_DOMAINS          = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_lock,
  input  logic                 sw_rst_req,
  output logic                 pll_reset_n,
  output logic [N_DOMAINS-1:0] rst_out,
  output logic                 ready,
  output logic [3:0]           retry_cnt,
  output logic [7:0]           loss_cnt
);

  // Counter must hold the largest terminal value of any timed state.
  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CD  = (LOCK_TIMEOUT > STAGE_GAP) ? LOCK_TIMEOUT : STAGE_GAP;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Terminal counts: a state lasting K cycles exits when cnt == K-1.
  localparam logic [CNT_W-1:0] PRC_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  localparam logic [N_DOMAINS-1:0] ALL_ONES = {N_DOMAINS{1'b1}};

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 lock_meta;
  logic                 lock_s;
  logic [N_DOMAINS-1:0] rst_shift;

  // Releasing the next domain is a left shift: the lowest still-set bit
  // clears and already-cleared bits stay clear, so bits never glitch low
  // out of order. An all-zero result means the last domain just released.
  assign rst_shift = rst_out << 1;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Main sequencer: state, shared counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_PLL_RST;
      cnt         <= '0;
      pll_reset_n <= 1'b0;
      rst_out     <= ALL_ONES;
      ready       <= 1'b0;
      retry_cnt   <= 4'h0;
    end else if (sw_rst_req && (state != ST_PLL_RST)) begin
      // Software restart wins over every other transition and never
      // bumps the retry counter.
      state       <= ST_PLL_RST;
      cnt         <= '0;
      pll_reset_n <= 1'b0;
      rst_out     <= ALL_ONES;
      ready       <= 1'b0;
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (cnt == PRC_LAST) begin
            state       <= ST_WAIT_LOCK;
            cnt         <= '0;
            pll_reset_n <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state       <= ST_PLL_RST;
            cnt         <= '0;
            pll_reset_n <= 1'b0;
            if (retry_cnt != 4'hF) begin
              retry_cnt <= retry_cnt + 4'h1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_STABLE: begin
          // A single dropped lock cycle restarts the qualification window
          // without pulsing the PLL reset.
          if (!lock_s) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            cnt     <= '0;
            rst_out <= rst_shift;
            if (rst_shift == '0) begin
              state <= ST_RUN;
              ready <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_RELEASE: begin
          if (!lock_s) begin
            state       <= ST_PLL_RST;
            cnt         <= '0;
            pll_reset_n <= 1'b0;
            rst_out     <= ALL_ONES;
          end else if (cnt == GAP_LAST) begin
            cnt     <= '0;
            rst_out <= rst_shift;
            if (rst_shift == '0) begin
              state <= ST_RUN;
              ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_RUN: begin
          // Counter holds here; RUN has no timeout.
          if (!lock_s) begin
            state       <= ST_PLL_RST;
            cnt         <= '0;
            pll_reset_n <= 1'b0;
            rst_out     <= ALL_ONES;
            ready       <= 1'b0;
          end
        end

        default: begin
          state       <= ST_PLL_RST;
          cnt         <= '0;
          pll_reset_n <= 1'b0;
          rst_out     <= ALL_ONES;
          ready       <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  // Lock-loss counter; counts even when a software request arrives on the
  // same edge, since the loss itself still happened.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= 8'h00;
    end else if ((state == ST_RUN) && !lock_s && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'h01;
    end
  end
`else
  assign loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: directed plus randomized bench for pll_rst_seq.
// The reference model tracks the sequence as phase + elapsed cycles +
// number of released domains, and derives the expected outputs from those.
module tb_pll_rst_seq;

  localparam int PRC = 4;
  localparam int LSC = 8;
  localparam int LTO = 32;
  localparam int GAP = 2;
  localparam int ND  = 3;

  localparam int PH_PULSE   = 0;
  localparam int PH_WAIT    = 1;
  localparam int PH_STABLE  = 2;
  localparam int PH_RELEASE = 3;
  localparam int PH_RUN     = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          pll_lock;
  logic          sw_rst_req;
  logic          pll_reset_n;
  logic [ND-1:0] rst_out;
  logic          ready;
  logic [3:0]    retry_cnt;
  logic [7:0]    loss_cnt;

  always #5 clk = ~clk;

  pll_rst_seq #(
    .PLL_RST_CYCLES    (PRC),
    .LOCK_STABLE_CYCLES(LSC),
    .LOCK_TIMEOUT      (LTO),
    .STAGE_GAP         (GAP),
    .N_DOMAINS         (ND)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .sw_rst_req (sw_rst_req),
    .pll_reset_n(pll_reset_n),
    .rst_out    (rst_out),
    .ready      (ready),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  // ---------------- scoreboard counts ----------------
  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_phase;
  int m_age;
  int m_rel;
  int m_retry;
  int m_loss;
  bit lock_q[$];

  task automatic model_reset();
    m_phase = PH_PULSE;
    m_age   = 0;
    m_rel   = 0;
    m_retry = 0;
    m_loss  = 0;
    lock_q  = '{1'b0, 1'b0};
  endtask

  task automatic enter(input int p);
    m_phase = p;
    m_age   = 0;
    if (p == PH_PULSE) m_rel = 0;
  endtask

  // One clock edge; lock is seen two edges after it is sampled.
  task automatic model_step();
    bit ls;
    ls = lock_q.pop_front();
    lock_q.push_back(pll_lock);
    if (sw_rst_req && m_phase != PH_PULSE) begin
      if (m_phase == PH_RUN && !ls) m_loss = (m_loss < 255) ? m_loss + 1 : 255;
      enter(PH_PULSE);
    end else begin
      case (m_phase)
        PH_PULSE: begin
          m_age++;
          if (m_age == PRC) enter(PH_WAIT);
        end
        PH_WAIT: begin
          if (ls) enter(PH_STABLE);
          else begin
            m_age++;
            if (m_age == LTO) begin
              m_retry = (m_retry < 15) ? m_retry + 1 : 15;
              enter(PH_PULSE);
            end
          end
        end
        PH_STABLE: begin
          if (!ls) enter(PH_WAIT);
          else begin
            m_age++;
            if (m_age == LSC) begin
              enter(PH_RELEASE);
              m_rel = 1;
              if (m_rel == ND) enter(PH_RUN);
            end
          end
        end
        PH_RELEASE: begin
          if (!ls) enter(PH_PULSE);
          else begin
            m_age++;
            if (m_age == GAP) begin
              m_rel++;
              m_age = 0;
              if (m_rel == ND) enter(PH_RUN);
            end
          end
        end
        default: begin
          if (!ls) begin
            m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            enter(PH_PULSE);
          end
        end
      endcase
    end
  endtask

  function automatic logic [ND-1:0] exp_rst();
    logic [ND-1:0] r;
    for (int i = 0; i < ND; i++) r[i] = (i >= m_rel);
    return r;
  endfunction

  function automatic int exp_loss();
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    return m_loss;
`else
    return 0;
`endif
  endfunction

  task automatic check_all();
    chk("pll_reset_n", pll_reset_n, (m_phase != PH_PULSE));
    chk("rst_out",     rst_out,     exp_rst());
    chk("ready",       ready,       (m_phase == PH_RUN));
    chk("retry_cnt",   retry_cnt,   m_retry);
    chk("loss_cnt",    loss_cnt,    exp_loss());
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: drive, take the edge, check, return at next negedge.
  task automatic cycle(input logic lock, input logic sw);
    pll_lock   = lock;
    sw_rst_req = sw;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1 check_all();
    @(negedge clk);
  endtask

  // Hold lock high until ready; returns edges taken (-1 on budget expiry)
  // and the number of cycles pll_reset_n was seen low on the way.
  task automatic run_to_ready(input int budget, output int lat, output int lows);
    lat  = -1;
    lows = 0;
    for (int i = 0; i < budget; i++) begin
      cycle(1'b1, 1'b0);
      if (pll_reset_n === 1'b0) lows++;
      if (ready === 1'b1) begin
        lat = i + 1;
        break;
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat;
    int lows;
    int k;
    int last_fall;
    int period;
    logic prev_rn;
    int seg;
    bit done;

    rst_n      = 1'b0;
    pll_lock   = 1'b1;
    sw_rst_req = 1'b0;
    model_reset();
    #12 check_all();

    // 1: clean bring-up
    @(negedge clk);
    rst_n = 1'b1;
    run_to_ready(100, lat, lows);
    chk("t1_ready_latency", lat, PRC + 1 + LSC + (ND - 1) * GAP);

    // 4: lock loss in RUN, 3-edge assertion latency
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0);
      if (rst_out === '1) begin
        lat = i + 1;
        break;
      end
    end
    chk("t4_loss_latency", lat, 3);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    chk("t4_loss_cnt", loss_cnt, 1);
`else
    chk("t4_loss_cnt", loss_cnt, 0);
`endif

    // 2: no lock -> periodic PLL reset pulses, retry counter saturates
    last_fall = -1;
    period    = 0;
    prev_rn   = pll_reset_n;
    for (int i = 0; i < 16 * (PRC + LTO) + 20; i++) begin
      cycle(1'b0, 1'b0);
      if (pll_reset_n === 1'b0 && prev_rn === 1'b1) begin
        if (last_fall >= 0) period = i - last_fall;
        last_fall = i;
      end
      prev_rn = pll_reset_n;
    end
    chk("t2_pulse_period", period, PRC + LTO);
    chk("t2_retry_sat", retry_cnt, 15);
    chk("t2_rst_out", rst_out, 3'b111);
    run_to_ready(200, lat, lows);
    chk("t2_recovered", (lat > 0), 1);

    // 3: one-cycle lock glitch in STABLE restarts qualification, no PLL reset
    cycle(1'b1, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (m_phase == PH_STABLE && m_age == 2) begin
        done = 1'b1;
        break;
      end
      cycle(1'b1, 1'b0);
    end
    chk("t3_reached_stable", done, 1);
    cycle(1'b0, 1'b0);
    run_to_ready(100, lat, lows);
    // 2 edges to see the glitch, 1 in WAIT_LOCK, full stable window, stages
    chk("t3_restart_latency", lat, 2 + 1 + LSC + (ND - 1) * GAP);
    chk("t3_no_pll_pulse", lows, 0);

    // 5: software request mid-release
    cycle(1'b1, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (m_phase == PH_RELEASE && m_rel == 2) begin
        done = 1'b1;
        break;
      end
      cycle(1'b1, 1'b0);
    end
    chk("t5_reached_100", done, 1);
    chk("t5_rst_out_before", rst_out, 3'b100);
    cycle(1'b1, 1'b1);
    chk("t5_rst_out_after", rst_out, 3'b111);
    chk("t5_pll_low", pll_reset_n, 0);
    k = 1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0);
      if (pll_reset_n === 1'b0) k++;
      else break;
    end
    chk("t5_pll_low_len", k, PRC);

    // random: lock runs/dropouts with occasional software requests
    for (int s = 0; s < 60; s++) begin
      seg = $urandom_range(1, 60);
      for (int i = 0; i < seg; i++) cycle(1'b1, ($urandom_range(0, 49) == 0));
      seg = $urandom_range(1, 40);
      for (int i = 0; i < seg; i++) cycle(1'b0, ($urandom_range(0, 49) == 0));
    end

    // 6: asynchronous reset mid-RUN
    run_to_ready(200, lat, lows);
    chk("t6_in_run", ready, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    cycle(1'b1, 1'b0);
    rst_n = 1'b1;
    run_to_ready(100, lat, lows);
    chk("t6_ready_latency", lat, PRC + 1 + LSC + (ND - 1) * GAP);
    chk("t6_loss_cleared", loss_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
